// File: rtl/cpu_fetch.sv
// Instruction fetch: reset vector, opcode and operand bytes.
// Hands a complete instruction to execute over valid/ready.
module cpu_fetch #(
  parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_data,
  output logic [7:0]  IR,
  input  logic [4:0]  adr_mode,
  output logic [7:0]  op_lo,
  output logic [7:0]  op_hi,
  output logic [15:0] pc_next,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        illegal,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val
);

  localparam logic [4:0] ADR_IMM       = 5'd2;
  localparam logic [4:0] ADR_ZPG       = 5'd3;
  localparam logic [4:0] ADR_ZPG_RMW   = 5'd4;
  localparam logic [4:0] ADR_ZPG_X_Y   = 5'd5;
  localparam logic [4:0] ADR_ZPG_X_RMW = 5'd6;
  localparam logic [4:0] ADR_ZPG_IND_Y = 5'd7;
  localparam logic [4:0] ADR_ABS_X_IND = 5'd8;
  localparam logic [4:0] ADR_REL       = 5'd9;
  localparam logic [4:0] ADR_STACK_BRK = 5'd10;
  localparam logic [4:0] ADR_ABS       = 5'd11;
  localparam logic [4:0] ADR_ABS_RMW   = 5'd12;
  localparam logic [4:0] ADR_ABS_X_Y   = 5'd13;
  localparam logic [4:0] ADR_ABS_X_RMW = 5'd14;
  localparam logic [4:0] ADR_ABS_JSR   = 5'd15;
  localparam logic [4:0] ADR_ABS_JMP   = 5'd16;
  localparam logic [4:0] ADR_ABS_IND   = 5'd17;
  localparam logic [4:0] ADR_INVAL     = 5'd31;

  typedef enum logic [2:0] {
    VEC_LO, VEC_HI, OPC, LEN, OPR2, HOLD
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc;
  logic [1:0]  n;
  logic        rd;
  logic        redirect;
  logic        ld_vlo, ld_vhi, ld_ir;
  logic        ld_lo, ld_hi, inc;

  always_comb begin
    case (adr_mode)
      ADR_ABS, ADR_ABS_RMW, ADR_ABS_X_Y,
      ADR_ABS_X_RMW, ADR_ABS_JSR,
      ADR_ABS_JMP, ADR_ABS_IND: n = 2'd2;
      ADR_IMM, ADR_ZPG, ADR_ZPG_RMW,
      ADR_ZPG_X_Y, ADR_ZPG_X_RMW,
      ADR_ZPG_IND_Y, ADR_ABS_X_IND,
      ADR_REL, ADR_STACK_BRK: n = 2'd1;
      default: n = 2'd0;
    endcase
  end

  assign redirect = pc_load &&
    (state != VEC_LO) && (state != VEC_HI);

  always_comb begin
    state_n  = state;
    rd       = 1'b0;
    mem_addr = pc;
    ld_vlo   = 1'b0;
    ld_vhi   = 1'b0;
    ld_ir    = 1'b0;
    ld_lo    = 1'b0;
    ld_hi    = 1'b0;
    inc      = 1'b0;
    unique case (state)
      VEC_LO: begin
        rd       = 1'b1;
        mem_addr = RESET_VEC;
        if (mem_rdy) begin
          ld_vlo  = 1'b1;
          state_n = VEC_HI;
        end
      end
      VEC_HI: begin
        rd       = 1'b1;
        mem_addr = RESET_VEC + 16'd1;
        if (mem_rdy) begin
          ld_vhi  = 1'b1;
          state_n = OPC;
        end
      end
      OPC: begin
        rd = 1'b1;
        if (mem_rdy) begin
          ld_ir   = 1'b1;
          inc     = 1'b1;
          state_n = LEN;
        end
      end
      LEN: begin
        if (n == 2'd0) begin
          state_n = HOLD;
        end else begin
          rd = 1'b1;
          if (mem_rdy) begin
            ld_lo   = 1'b1;
            inc     = 1'b1;
            state_n = (n == 2'd1) ? HOLD : OPR2;
          end
        end
      end
      OPR2: begin
        rd = 1'b1;
        if (mem_rdy) begin
          ld_hi   = 1'b1;
          inc     = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) state_n = OPC;
      end
      default: state_n = VEC_LO;
    endcase
    // Redirect discards whatever byte is arriving this cycle.
    if (redirect) begin
      state_n = OPC;
      ld_ir   = 1'b0;
      ld_lo   = 1'b0;
      ld_hi   = 1'b0;
      inc     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= VEC_LO;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= 16'h0000;
      IR    <= 8'hEA;
      op_lo <= 8'h00;
      op_hi <= 8'h00;
    end else begin
      if (ld_vlo)        pc[7:0]  <= mem_data;
      else if (ld_vhi)   pc[15:8] <= mem_data;
      else if (redirect) pc <= pc_load_val;
      else if (inc)      pc <= pc + 16'd1;
      if (ld_ir) begin
        IR    <= mem_data;
        op_lo <= 8'h00;
        op_hi <= 8'h00;
      end
      if (ld_lo) op_lo <= mem_data;
      if (ld_hi) op_hi <= mem_data;
    end
  end

  assign mem_rd      = rd & ~rst;
  assign pc_next     = pc;
  assign instr_valid = (state == HOLD);
  assign illegal     = instr_valid &&
    (adr_mode == ADR_INVAL);

endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
- Instruction fetch stage sitting directly upstream of CPU_control.
- Owns the PC and reads the reset vector, the opcode and 0–2 operand bytes over the CPU read port, and latches the opcode into IR.
- Feeds IR to CPU_control and reads back CPU_control's adr_mode to size the operand fetch.
- Presents a complete instruction to the execute sequencer through a valid/ready handshake.

Parameters:
- RESET_VEC, 16'hFFFC, address of the low byte of the reset vector; the high byte is read from RESET_VEC+1.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- mem_addr  out  16  read address
- mem_rd  out  1  read request; the byte is consumed on the edge where mem_rd & mem_rdy
- mem_rdy  in  1  memory has mem_data valid this cycle
- mem_data  in  8  read data
- IR  out  8  opcode register, drives CPU_control IR
- adr_mode  in  5  addressing mode from CPU_control, decoded combinationally from IR (codes per config.vh)
- op_lo  out  8  first operand byte
- op_hi  out  8  second operand byte
- pc_next  out  16  address of the byte after the current instruction
- instr_valid  out  1  IR/op_lo/op_hi/pc_next hold a complete instruction
- instr_ready  in  1  execute stage accepts the instruction
- illegal  out  1  qualifies instr_valid: adr_mode == ADR_INVAL
- pc_load  in  1  redirect PC (jump, branch, RTS/RTI, interrupt)
- pc_load_val  in  16  new PC

Behaviour:
- Reset, asynchronous on rst=1:
  - state=VEC_LO, PC=0, IR=8'hEA, op_lo=op_hi=0.
  - instr_valid=0, illegal=0, mem_rd=0.
  - Reset mid-transfer abandons the transfer with no partial update.
- Operand count n from adr_mode:
  - n=2: ABS, ABS_RMW, ABS_X_Y, ABS_X_RMW, ABS_JSR, ABS_JMP, ABS_IND.
  - n=1: IMM, ZPG, ZPG_RMW, ZPG_X_Y, ZPG_X_RMW, ZPG_IND_Y, ABS_X_IND, REL, STACK_BRK.
  - n=0: all other modes, including INVAL.
- States:
  - VEC_LO: mem_rd=1, addr=RESET_VEC. On accept: PC[7:0]=data, go to VEC_HI.
  - VEC_HI: mem_rd=1, addr=RESET_VEC+1. On accept: PC[15:8]=data, go to OPC.
  - OPC: mem_rd=1, addr=PC. On accept: IR=data, PC=PC+1, op_lo=op_hi=0, go to LEN.
  - LEN: adr_mode is now stable from the new IR. If n=0, no read; go to HOLD. Else mem_rd=1, addr=PC; on accept op_lo=data, PC+1, then HOLD if n=1, OPR2 if n=2.
  - OPR2: mem_rd=1, addr=PC. On accept: op_hi=data, PC+1, go to HOLD.
  - HOLD: instr_valid=1, mem_rd=0. Outputs stay stable until instr_valid & instr_ready, then go to OPC the same edge.
- While mem_rdy=0 the state holds and mem_addr stays stable; no timeout.
- pc_next = PC (registered) and is valid in HOLD.
- illegal = instr_valid & (adr_mode == ADR_INVAL).
- PC wraps 16'hFFFF -> 16'h0000, with no carry out.
- pc_load:
  - Ignored in VEC_LO/VEC_HI.
  - In any other state: PC=pc_load_val, instr_valid drops next cycle, any in-flight read is discarded, and the next state is OPC.
  - pc_load has priority over a simultaneous mem accept and a simultaneous handshake.
  - pc_load together with instr_ready in HOLD: the instruction is consumed and PC comes from pc_load_val.
- Minimum latency from opcode accept to instr_valid, zero-wait memory: n=0 → 2 cycles, n=1 → 2 cycles, n=2 → 3 cycles.

Test Plan:
- Reset vector: mem[FFFC]=00, mem[FFFD]=80, mem[8000]=A9 (LDA #), mem[8001]=42 -> first mem_addr=FFFC, FFFD, 8000, 8001; instr_valid with IR=A9, op_lo=42, pc_next=8002.
- 3-byte instruction: mem[8000]=4C 34 12 (JMP abs) -> op_lo=34, op_hi=12, pc_next=8003; instr_valid held 5 cycles while instr_ready=0, outputs unchanged; after ready, mem_addr=8003.
- Implied instruction with wait states: mem[8000]=E8 (INX), mem_rdy low 3 cycles -> mem_addr stays 8000; no operand read issued; IR=E8, pc_next=8001.
- Redirect: pc_load=1, pc_load_val=C000 asserted during an OPR2 wait -> op_hi not written; next request is mem_addr=C000.
- Invalid opcode: mem[8000]=02 -> adr_mode=INVAL, no operand read, instr_valid=1 with illegal=1, pc_next=8001.
- Wrap and async reset: PC=FFFF, opcode A9 -> operand read at 0000, pc_next=0001; rst pulse mid-read -> next request is FFFC, instr_valid=0 immediately.
